// File: rtl/alu_op_sequencer.sv
// Command/response sequencer for a combinational ALU: registers the ALU bus, waits SETTLE_CYCLES, then captures.
// Optional golden-model self-check is enabled with `define ALU_SEQ_SELFCHECK_EN.
module alu_op_sequencer #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [15:0]      op_count,
    output logic             mismatch
);

    typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [3:0]       alu_opcode_reg, alu_opcode_next;
    logic [WIDTH-1:0] alu_input1_reg, alu_input1_next;
    logic [WIDTH-1:0] alu_input2_reg, alu_input2_next;
    logic [4:0]       alu_shift_reg, alu_shift_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic [WIDTH-1:0] rsp_result_reg, rsp_result_next;
    logic [3:0]       rsp_flags_reg, rsp_flags_next;
    logic [15:0]      op_count_reg, op_count_next;
    logic             capture;
    logic             rsp_hs;

    assign capture = (state_reg == SETTLE) && (cnt_reg == 4'd1);
    assign rsp_hs  = rsp_valid_reg && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            alu_opcode_reg <= '0;
            alu_input1_reg <= '0;
            alu_input2_reg <= '0;
            alu_shift_reg  <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_flags_reg  <= '0;
            op_count_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            alu_opcode_reg <= alu_opcode_next;
            alu_input1_reg <= alu_input1_next;
            alu_input2_reg <= alu_input2_next;
            alu_shift_reg  <= alu_shift_next;
            rsp_valid_reg  <= rsp_valid_next;
            rsp_result_reg <= rsp_result_next;
            rsp_flags_reg  <= rsp_flags_next;
            op_count_reg   <= op_count_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        alu_opcode_next = alu_opcode_reg;
        alu_input1_next = alu_input1_reg;
        alu_input2_next = alu_input2_reg;
        alu_shift_next  = alu_shift_reg;
        rsp_valid_next  = rsp_valid_reg;
        rsp_result_next = rsp_result_reg;
        rsp_flags_next  = rsp_flags_reg;
        op_count_next   = op_count_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    alu_opcode_next = cmd_opcode;
                    alu_input1_next = cmd_a;
                    alu_input2_next = cmd_b;
                    alu_shift_next  = cmd_shift;
                    cnt_next        = SETTLE_INIT;
                    state_next      = SETTLE;
                end
            end
            SETTLE: begin
                if (capture) begin
                    rsp_result_next = alu_result;
                    rsp_flags_next  = alu_flags;
                    rsp_valid_next  = 1'b1;
                    state_next      = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                // alu_* stay untouched here so the ALU output remains valid while the response is stalled
                if (rsp_hs) begin
                    rsp_valid_next = 1'b0;
                    op_count_next  = op_count_reg + 16'd1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Held low during reset so nothing upstream sees a handshake that the reset would discard
    assign cmd_ready      = (state_reg == IDLE) && !rst;
    assign alu_opcode     = alu_opcode_reg;
    assign alu_input1     = alu_input1_reg;
    assign alu_input2     = alu_input2_reg;
    assign alu_shiftValue = alu_shift_reg;
    assign rsp_valid      = rsp_valid_reg;
    assign rsp_result     = rsp_result_reg;
    assign rsp_flags      = rsp_flags_reg;
    assign op_count       = op_count_reg;

`ifdef ALU_SEQ_SELFCHECK_EN
    localparam int IW = $clog2(2 * WIDTH);

    logic [2*WIDTH-1:0] dbl;
    logic [IW-1:0]      amt;
    logic [WIDTH-1:0]   rol_res, ror_res;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   exp_result;
    logic               exp_carry, exp_ovf;
    logic [3:0]         exp_flags;
    logic               mismatch_reg, mismatch_next;

    assign dbl = {alu_input1_reg, alu_input1_reg};
    assign amt = IW'(32'(alu_shift_reg) % WIDTH);
    assign sum = {1'b0, alu_input1_reg} + {1'b0, alu_input2_reg};

    // Rotates read the doubled operand so any amount in 0..WIDTH-1 is a plain bit pick
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rot
            assign rol_res[gi] = dbl[IW'(gi + WIDTH) - amt];
            assign ror_res[gi] = dbl[IW'(gi) + amt];
        end
    endgenerate

    always_comb begin
        exp_result = '0;
        exp_carry  = 1'b0;
        exp_ovf    = 1'b0;
        case (alu_opcode_reg)
            4'd0: exp_result = rol_res;
            4'd1: exp_result = ror_res;
            4'd2: exp_result = (alu_input1_reg > alu_input2_reg) ? alu_input1_reg : alu_input2_reg;
            4'd3: exp_result = (alu_input1_reg < alu_input2_reg) ? alu_input1_reg : alu_input2_reg;
            4'd4: begin
                exp_result = sum[WIDTH-1:0];
                exp_carry  = sum[WIDTH];
                exp_ovf    = (alu_input1_reg[WIDTH-1] == alu_input2_reg[WIDTH-1]) &&
                             (sum[WIDTH-1] != alu_input1_reg[WIDTH-1]);
            end
            4'd5: exp_result = {{(WIDTH-1){1'b0}}, alu_input1_reg == alu_input2_reg};
            4'd6: exp_result = {{(WIDTH-1){1'b0}}, alu_input1_reg != alu_input2_reg};
            4'd7: exp_result = alu_input1_reg & alu_input2_reg;
            default: exp_result = '0;
        endcase
        exp_flags = {exp_carry, exp_result == '0, exp_ovf, exp_result[WIDTH-1]};
    end

    always_comb begin
        mismatch_next = mismatch_reg;
        if (capture) begin
            mismatch_next = ({alu_result, alu_flags} != {exp_result, exp_flags});
        end else if (rsp_hs) begin
            mismatch_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_reg <= 1'b0;
        end else begin
            mismatch_reg <= mismatch_next;
        end
    end

    assign mismatch = mismatch_reg;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed vector table, stall/reset sequences and randomized ops vs a reference model.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with SETTLE_CYCLES=1
    logic        rst = 1'b1, cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b0, mismatch;
    logic [3:0]  cmd_opcode = '0, alu_opcode, alu_flags, rsp_flags;
    logic [7:0]  cmd_a = '0, cmd_b = '0, alu_input1, alu_input2, alu_result, rsp_result;
    logic [4:0]  cmd_shift = '0, alu_shiftValue;
    logic [15:0] op_count;
    logic        force_zero = 1'b0;

    // DUT with SETTLE_CYCLES=4
    logic        rst_4 = 1'b1, cmd_valid_4 = 1'b0, cmd_ready_4, rsp_valid_4, rsp_ready_4 = 1'b0, mismatch_4;
    logic [3:0]  cmd_opcode_4 = '0, alu_opcode_4, alu_flags_4, rsp_flags_4;
    logic [7:0]  cmd_a_4 = '0, cmd_b_4 = '0, alu_input1_4, alu_input2_4, alu_result_4, rsp_result_4;
    logic [4:0]  cmd_shift_4 = '0, alu_shiftValue_4;
    logic [15:0] op_count_4;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_count = '0;

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
        .alu_opcode(alu_opcode), .alu_input1(alu_input1), .alu_input2(alu_input2),
        .alu_shiftValue(alu_shiftValue), .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .op_count(op_count), .mismatch(mismatch)
    );

    alu_op_sequencer #(.WIDTH(8), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst_4), .cmd_valid(cmd_valid_4), .cmd_ready(cmd_ready_4),
        .cmd_opcode(cmd_opcode_4), .cmd_a(cmd_a_4), .cmd_b(cmd_b_4), .cmd_shift(cmd_shift_4),
        .alu_opcode(alu_opcode_4), .alu_input1(alu_input1_4), .alu_input2(alu_input2_4),
        .alu_shiftValue(alu_shiftValue_4), .alu_result(alu_result_4), .alu_flags(alu_flags_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4), .rsp_result(rsp_result_4),
        .rsp_flags(rsp_flags_4), .op_count(op_count_4), .mismatch(mismatch_4)
    );

    // Reference ALU in integer arithmetic; returns {result, carry, zero, overflow, sign}
    function automatic logic [11:0] ref_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input logic [4:0] sh);
        int ai, bi, r, amt, sa, sb, ss;
        bit c, v;
        ai = int'(a); bi = int'(b); amt = int'(sh) % 8; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: r = ((ai << amt) | (ai >> (8 - amt))) & 255;
            4'd1: r = ((ai >> amt) | (ai << (8 - amt))) & 255;
            4'd2: r = (ai > bi) ? ai : bi;
            4'd3: r = (ai < bi) ? ai : bi;
            4'd4: begin
                r  = (ai + bi) & 255;
                c  = (ai + bi) > 255;
                sa = (ai > 127) ? ai - 256 : ai;
                sb = (bi > 127) ? bi - 256 : bi;
                ss = sa + sb;
                v  = (ss > 127) || (ss < -128);
            end
            4'd5: r = (ai == bi) ? 1 : 0;
            4'd6: r = (ai != bi) ? 1 : 0;
            4'd7: r = ai & bi;
            default: r = 0;
        endcase
        return {r[7:0], c, (r == 0), v, r[7]};
    endfunction

    always_comb begin
        {alu_result, alu_flags} = ref_alu(alu_opcode, alu_input1, alu_input2, alu_shiftValue);
        if (force_zero) alu_result = 8'h00;
    end

    always_comb begin
        {alu_result_4, alu_flags_4} = ref_alu(alu_opcode_4, alu_input1_4, alu_input2_4, alu_shiftValue_4);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, input logic [4:0] sh);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        #1 cmd_valid = 1'b0;
        chk("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic await_rsp(input int exp_lat, input string tag);
        int lat;
        bit seen;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk({tag, "_rsp_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [4:0] sh, input string tag);
        logic [11:0] e;
        e = ref_alu(op, a, b, sh);
        chk({tag, "_result_flags"}, 32'({rsp_result, rsp_flags}), 32'(e));
        chk({tag, "_alu_bus"}, 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'({op, a, b, sh}));
        chk({tag, "_mismatch"}, 32'(mismatch), 32'd0);
    endtask

    task automatic handshake(input int stall, input string tag);
        logic [11:0] held;
        held = {rsp_result, rsp_flags};
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_stall_hold"}, 32'({rsp_valid, cmd_ready, rsp_result, rsp_flags}), 32'({2'b10, held}));
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        chk({tag, "_after_hs"}, 32'({rsp_valid, cmd_ready}), 32'b01);
        chk({tag, "_op_count"}, 32'(op_count), 32'(exp_count));
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] sh;
        logic [7:0] res;
        logic [3:0] fl;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [3:0] r_op;
        logic [7:0] r_a, r_b;
        logic [4:0] r_sh;
        int lat;
        bit seen;

        // flags are {carry, zero, overflow, sign}
        vecs[0]  = '{4'd4, 8'h7F, 8'h01, 5'd0, 8'h80, 4'b0011};
        vecs[1]  = '{4'd4, 8'hFF, 8'h01, 5'd0, 8'h00, 4'b1100};
        vecs[2]  = '{4'd0, 8'h81, 8'h00, 5'd1, 8'h03, 4'b0000};
        vecs[3]  = '{4'd1, 8'h81, 8'h00, 5'd1, 8'hC0, 4'b0001};
        vecs[4]  = '{4'd2, 8'h10, 8'hF0, 5'd0, 8'hF0, 4'b0001};
        vecs[5]  = '{4'd3, 8'h10, 8'hF0, 5'd0, 8'h10, 4'b0000};
        vecs[6]  = '{4'd5, 8'h05, 8'h05, 5'd0, 8'h01, 4'b0000};
        vecs[7]  = '{4'd6, 8'h05, 8'h05, 5'd0, 8'h00, 4'b0100};
        vecs[8]  = '{4'd7, 8'hF0, 8'h3C, 5'd0, 8'h30, 4'b0000};
        vecs[9]  = '{4'd0, 8'h81, 8'h00, 5'd9, 8'h03, 4'b0000};
        vecs[10] = '{4'd1, 8'h01, 8'h00, 5'd8, 8'h01, 4'b0000};
        vecs[11] = '{4'd9, 8'h12, 8'h34, 5'd3, 8'h00, 4'b0100};
        vecs[12] = '{4'd4, 8'h80, 8'h80, 5'd0, 8'h00, 4'b1110};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", 32'(cmd_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset_ctrl", 32'({cmd_ready, rsp_valid, mismatch}), 32'b100);
        chk("reset_alu_bus", 32'({alu_opcode, alu_input1, alu_input2, alu_shiftValue}), 32'd0);
        chk("reset_rsp", 32'({rsp_result, rsp_flags}), 32'd0);
        chk("reset_op_count", 32'(op_count), 32'd0);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            await_rsp(1, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_result", i), 32'(rsp_result), 32'(vecs[i].res));
            chk($sformatf("vec%0d_flags", i), 32'(rsp_flags), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_mismatch", i), 32'(mismatch), 32'd0);
            handshake(0, $sformatf("vec%0d", i));
        end

        // Stalled response with a waiting command
        issue(4'd4, 8'h12, 8'h34, 5'd0);
        await_rsp(1, "stall");
        chk("stall_first_result", 32'(rsp_result), 32'h46);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_opcode = 4'd3; cmd_a = 8'h55; cmd_b = 8'h22; cmd_shift = 5'd0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", 32'({rsp_valid, cmd_ready, rsp_result, alu_opcode}), 32'({2'b10, 8'h46, 4'd4}));
            chk("stall_count", 32'(op_count), 32'(exp_count));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        chk("stall_release_idle", 32'({cmd_ready, rsp_valid, alu_opcode}), 32'({2'b10, 4'd4}));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        await_rsp(1, "queued");
        check_rsp(4'd3, 8'h55, 8'h22, 5'd0, "queued");
        handshake(0, "queued");

        // Golden-model check against a faulty ALU result
`ifdef ALU_SEQ_SELFCHECK_EN
        force_zero = 1'b1;
        issue(4'd7, 8'hF0, 8'h3C, 5'd0);
        await_rsp(1, "faulty");
        chk("faulty_mismatch", 32'({rsp_valid, mismatch, rsp_result}), 32'({2'b11, 8'h00}));
        handshake(0, "faulty");
        chk("faulty_cleared", 32'(mismatch), 32'd0);
        force_zero = 1'b0;
`endif
        issue(4'd7, 8'hF0, 8'h3C, 5'd0);
        await_rsp(1, "good_and");
        check_rsp(4'd7, 8'hF0, 8'h3C, 5'd0, "good_and");
        handshake(0, "good_and");

        // Randomized ops with random gaps and response stalls
        for (int n = 0; n < 60; n++) begin
            r_op = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            r_a  = 8'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? r_a : 8'($urandom);
            r_sh = 5'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(r_op, r_a, r_b, r_sh);
            await_rsp(1, $sformatf("rnd%0d", n));
            check_rsp(r_op, r_a, r_b, r_sh, $sformatf("rnd%0d", n));
            handshake(int'($urandom_range(0, 3)), $sformatf("rnd%0d", n));
        end

        // SETTLE_CYCLES=4 instance: latency, then reset during an in-flight op
        rst_4 = 1'b0;
        @(negedge clk);
        chk("d4_reset_ready", 32'({cmd_ready_4, rsp_valid_4, op_count_4}), 32'({2'b10, 16'd0}));
        cmd_valid_4 = 1'b1; cmd_opcode_4 = 4'd4; cmd_a_4 = 8'h7F; cmd_b_4 = 8'h01; cmd_shift_4 = 5'd0;
        @(posedge clk);
        #1 cmd_valid_4 = 1'b0;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid_4) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk("d4_latency", 32'({seen, 8'(lat)}), 32'({1'b1, 8'd4}));
        chk("d4_result", 32'({rsp_result_4, rsp_flags_4}), 32'({8'h80, 4'b0011}));
        rsp_ready_4 = 1'b1;
        @(posedge clk);
        #1 rsp_ready_4 = 1'b0;
        @(negedge clk);
        chk("d4_count", 32'(op_count_4), 32'd1);
        cmd_valid_4 = 1'b1; cmd_opcode_4 = 4'd7; cmd_a_4 = 8'hFF; cmd_b_4 = 8'h0F;
        @(posedge clk);
        #1 cmd_valid_4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_4 = 1'b1;
        #1;
        chk("d4_ready_in_reset", 32'(cmd_ready_4), 32'd0);
        @(negedge clk);
        rst_4 = 1'b0;
        #1;
        chk("d4_after_reset", 32'({rsp_valid_4, cmd_ready_4, op_count_4}), 32'({2'b01, 16'd0}));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid_4) seen = 1'b1;
        end
        chk("d4_no_stale_rsp", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
